// File: rtl/ota_trim_sar_ctrl.sv
// OTA offset-trim sequencer: powers the OTA, shorts its inputs and resolves the
// trim code MSB-first by successive approximation against the comparator.
module ota_trim_sar_ctrl #(
    parameter int TRIM_W        = 6,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              cmp_i,
    input  logic              load_i,
    input  logic [TRIM_W-1:0] load_trim_i,
    input  logic              pwrdn_i,
    output logic              ota_en_o,
    output logic              in_short_o,
    output logic [TRIM_W-1:0] trim_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_o,
    output logic [1:0]        state_o
);

    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W = $clog2(TRIM_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(TRIM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PWR  = 2'd1,
        S_BIT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cmp_s;
    logic [TRIM_W-1:0]      bit_code;

    assign state_o = state;
    assign cmp_s   = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_i};
        end
    end

    // Code after resolving the current bit: drop it if the comparator says the
    // trial is too large, then raise the next lower bit as the new trial.
    always_comb begin
        bit_code = trim_o;
        if (cmp_s) begin
            bit_code[bit_idx] = 1'b0;
        end
        if (bit_idx != '0) begin
            bit_code[bit_idx - IDX_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            trim_o     <= '0;
            ota_en_o   <= 1'b0;
            in_short_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state      <= S_PWR;
                        ota_en_o   <= 1'b1;
                        in_short_o <= 1'b1;
                        busy_o     <= 1'b1;
                        valid_o    <= 1'b0;
                        trim_o     <= '0;
                        cnt        <= '0;
                    end else if (load_i) begin
                        trim_o   <= load_trim_i;
                        valid_o  <= 1'b0;
                        ota_en_o <= 1'b1;
                    end else if (pwrdn_i) begin
                        ota_en_o <= 1'b0;
                        valid_o  <= 1'b0;
                    end
                end
                S_PWR: begin
                    if (cnt == CNT_LAST) begin
                        cnt              <= '0;
                        bit_idx          <= IDX_MSB;
                        trim_o[TRIM_W-1] <= 1'b1;
                        state            <= S_BIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_BIT: begin
                    if (cnt == CNT_LAST) begin
                        trim_o <= bit_code;
                        cnt    <= '0;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - IDX_W'(1);
                        end else begin
                            state      <= S_DONE;
                            in_short_o <= 1'b0;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            valid_o    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ota_trim_sar_ctrl.md
Name: ota_trim_sar_ctrl

Overview:
- Sequencer for the digital OTA offset trim; runs a successive-approximation (SAR) calibration loop.
- On request, powers the OTA and shorts its inputs, then resolves a TRIM_W-bit trim code one bit at a time from the OTA's comparator output.
- Releases the input short when calibration completes and holds the code.
- Also accepts a manual trim load and a power-down request while idle.

Parameters:
- TRIM_W, 6, width of the trim code (legal range 2..8).
- SETTLE_CYCLES, 16, cycles per phase (power-up and each bit). Must be >= SYNC_STAGES+2.
- SYNC_STAGES, 2, flops in the cmp_i synchronizer (legal range 2..3).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start_i  input  1  calibration request. Sampled only in IDLE.
- cmp_i  input  1  async OTA comparator output. 1 = offset too high, so the trial trim is too large.
- load_i  input  1  manual trim load strobe. Accepted only in IDLE.
- load_trim_i  input  TRIM_W  manual trim value.
- pwrdn_i  input  1  power-down request. Accepted only in IDLE.
- ota_en_o  output  1  OTA bias enable.
- in_short_o  output  1  short the OTA inputs (calibration mode).
- trim_o  output  TRIM_W  trim code to the OTA.
- busy_o  output  1  high in PWR and BIT states.
- done_o  output  1  one-cycle pulse when calibration ends.
- valid_o  output  1  trim_o holds a calibrated result.

Behaviour:
- Reset is synchronous; rst wins over every other input, including mid-calibration. On reset:
  - state = IDLE.
  - ota_en_o, in_short_o, busy_o, done_o, valid_o = 0.
  - trim_o = 0, phase counter = 0, bit index = 0.
  - Synchronizer flops = 0.
- cmp_i passes through SYNC_STAGES flops; the FSM uses only the synchronized value cmp_s.
- FSM states: IDLE, PWR, BIT, DONE.
- IDLE:
  - Input priority: start_i > load_i > pwrdn_i.
  - start_i=1 -> go to PWR next cycle. Same edge: ota_en_o=1, in_short_o=1, busy_o=1, valid_o=0, trim_o=0, counter=0.
  - load_i=1 (start_i=0) -> trim_o=load_trim_i, valid_o=0, ota_en_o=1; stay in IDLE.
  - pwrdn_i=1 (no start_i or load_i) -> ota_en_o=0, valid_o=0; trim_o is kept.
- PWR:
  - Counter counts 0..SETTLE_CYCLES-1.
  - On the cycle counter==SETTLE_CYCLES-1: counter=0, bit index=TRIM_W-1, trim_o[TRIM_W-1]=1, go to BIT.
- BIT:
  - Counter counts 0..SETTLE_CYCLES-1 with the trial code held stable on trim_o.
  - On the last cycle, sample cmp_s:
    - cmp_s=1 -> clear trim_o[idx].
    - cmp_s=0 -> keep trim_o[idx].
  - If idx>0: set trim_o[idx-1]=1, decrement idx, counter=0, stay in BIT.
  - If idx==0: go to DONE; in_short_o=0, busy_o=0.
- DONE:
  - Lasts exactly one cycle: done_o=1, valid_o=1.
  - Then goes to IDLE with done_o back to 0.
  - ota_en_o stays 1 and trim_o holds the result.
- Inputs ignored outside IDLE:
  - start_i, load_i and pwrdn_i are ignored while busy; a calibration cannot be aborted except by rst.
  - start_i held high in DONE has no effect; if still high in the following IDLE cycle, a new calibration begins.
- Latency: start_i sampled at edge T0 -> done_o high in cycle T0+(TRIM_W+1)*SETTLE_CYCLES+1. With defaults: 113 cycles.
- Result: if cmp = (trim > K) for a constant K, the final trim_o equals K, clamped to 2^TRIM_W-1.
- trim_o changes only at a phase boundary, a load or reset. It is never glitched mid-phase.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, trim_o=0.
- Comparator model cmp_i=(trim_o>37), pulse start_i -> busy_o high for 112 cycles, done_o pulses at T0+113, trim_o=6'd37, valid_o=1, in_short_o=0, ota_en_o=1. Repeat with K=0, giving trim_o=0; and K=63, giving trim_o=63.
- load_i=1 with load_trim_i=6'd21 in IDLE -> next cycle trim_o=21, valid_o=0, ota_en_o=1. The same load issued during BIT -> no change.
- Assert rst at cycle 50 of a calibration -> next cycle state IDLE, all outputs at reset values. A new start_i then completes normally with the same 113-cycle latency.
- start_i and load_i both asserted in IDLE -> calibration starts and the load is discarded. pwrdn_i in IDLE after a calibration -> ota_en_o=0, valid_o=0, trim_o kept.
- cmp_i toggling asynchronously (off-clock edges) within 2 cycles of a phase end -> no X on any output; each trim bit resolves to the synchronized value.
